// File: rtl/mips_reg_scoreboard.sv
// Issue-side register scoreboard: tracks in-flight register writes, stalls on
// RAW/WAW hazards and flags same-cycle writeback bypass for decode.

module mips_reg_sb_cell (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic set,
  input  logic clr,
  output logic pend_q,
  output logic pend_d
);
  // A new producer keeps the register pending even if the old value retires now.
  always_comb pend_d = flush ? 1'b0 : set ? 1'b1 : clr ? 1'b0 : pend_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
endmodule

module mips_reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [AW-1:0]   rs_addr_i,
  input  logic            rs_used_i,
  input  logic [AW-1:0]   rt_addr_i,
  input  logic            rt_used_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic            rd_we_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_addr_i,
  output logic            fwd_rs_o,
  output logic            fwd_rt_o,
  output logic [NREG-1:0] pending_o,
  output logic [AW:0]     pending_cnt_o,
  output logic [CNTW-1:0] stall_cnt_o
);
  logic [NREG-1:0] pend, pend_nxt, wb_hit, busy, set_v;
  logic            raw_rs, raw_rt, waw, fire;
  logic [AW:0]     cnt_nxt;

  assign pend[0]     = 1'b0;
  assign pend_nxt[0] = 1'b0;
  assign wb_hit[0]   = 1'b0;
  assign set_v[0]    = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_reg
      assign wb_hit[r] = wb_we_i && (wb_addr_i == AW'(r));
      assign set_v[r]  = fire && rd_we_i && (rd_addr_i == AW'(r));
      mips_reg_sb_cell u_cell (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush_i),
        .set    (set_v[r]),
        .clr    (wb_hit[r]),
        .pend_q (pend[r]),
        .pend_d (pend_nxt[r])
      );
    end
  endgenerate

  assign busy   = pend & ~wb_hit;
  assign raw_rs = rs_used_i && busy[rs_addr_i];
  assign raw_rt = rt_used_i && busy[rt_addr_i];
  assign waw    = rd_we_i && (rd_addr_i != '0) && busy[rd_addr_i];

  assign issue_ready_o = !flush_i && !raw_rs && !raw_rt && !waw;
  assign fire          = issue_valid_i && issue_ready_o;

  assign fwd_rs_o  = rs_used_i && pend[rs_addr_i] && wb_hit[rs_addr_i];
  assign fwd_rt_o  = rt_used_i && pend[rt_addr_i] && wb_hit[rt_addr_i];
  assign pending_o = pend;

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[i]};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) pending_cnt_o <= '0;
    else     pending_cnt_o <= cnt_nxt;

  always_ff @(posedge clk or posedge rst)
    if (rst)
      stall_cnt_o <= '0;
    else if (issue_valid_i && !issue_ready_o && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + CNTW'(1);
endmodule

// File: doc/mips_reg_scoreboard.md
Name: mips_reg_scoreboard

Overview:
- Issue-side companion to the MIPS register file. It tracks which architectural registers have a write in flight, between issue and writeback.
- It stalls issue on RAW and WAW hazards, and signals same-cycle writeback forwarding so decode never reads a stale register-file value.
- It sits between decode/issue and the writeback port that drives the register file's we / wr_addr0_i / wr_data_i.

Parameters:
- NREG, 32, number of architectural registers. Register 0 is hardwired zero and is never tracked.
- AW, 5, register address width, equal to log2(NREG).
- CNTW, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous and active-high. Clears all state.
- flush_i  in  1  pipeline flush: squash every in-flight write.
- issue_valid_i  in  1  decode presents an instruction.
- issue_ready_o  out  1  instruction may issue this cycle.
- rs_addr_i  in  AW  first source register.
- rs_used_i  in  1  instruction reads rs.
- rt_addr_i  in  AW  second source register.
- rt_used_i  in  1  instruction reads rt.
- rd_addr_i  in  AW  destination register.
- rd_we_i  in  1  instruction writes rd.
- wb_we_i  in  1  writeback writes the register file this cycle.
- wb_addr_i  in  AW  writeback destination register.
- fwd_rs_o  out  1  rs must take the writeback data (bypass) instead of the register file.
- fwd_rt_o  out  1  same as fwd_rs_o, for rt.
- pending_o  out  NREG  per-register pending bit vector. Bit 0 is always 0.
- pending_cnt_o  out  AW+1  population count of pending_o, registered.
- stall_cnt_o  out  CNTW  cycles with issue_valid_i=1 and issue_ready_o=0. Saturates at all-ones.

Behaviour:
- Reset (rst=1, asynchronous): pending_o=0, pending_cnt_o=0, stall_cnt_o=0.
  - issue_ready_o and fwd_* are combinational, so under reset they evaluate to 1, 0 and 0 for any issue_valid_i. issue_ready_o is still gated to 0 when flush_i=1.
- Definitions:
  - wb_hit(r) = wb_we_i & (wb_addr_i == r) & (r != 0).
  - busy(r) = pending[r] & !wb_hit(r).
- Hazard terms, all combinational, zero latency:
  - raw_rs = rs_used_i & busy(rs_addr_i). raw_rt is defined the same way for rt.
  - waw = rd_we_i & (rd_addr_i != 0) & busy(rd_addr_i).
- issue_ready_o = !flush_i & !raw_rs & !raw_rt & !waw. It is independent of issue_valid_i.
- fire = issue_valid_i & issue_ready_o.
- fwd_rs_o = rs_used_i & pending[rs_addr_i] & wb_hit(rs_addr_i). fwd_rt_o is defined the same way. Both are asserted regardless of fire.
- Next-state at the rising clock edge, in priority order:
  1. flush_i=1: pending clears to all-zero. Issue and writeback for that cycle are ignored for tracking.
  2. Clear: if wb_we_i, pending[wb_addr_i] <= 0. A writeback to a non-pending register is a no-op, not an error.
  3. Set: if fire & rd_we_i & rd_addr_i != 0, pending[rd_addr_i] <= 1. Set wins over clear when both target the same register, so the register stays pending for the new producer.
- Register 0: pending[0] is constant 0. Reads of r0 never stall or forward. Writes to r0 never set a pending bit.
- pending_cnt_o: registered equal to the population count of the next pending vector. Range 0..NREG-1.
- stall_cnt_o: increments by 1 on each edge where issue_valid_i & !issue_ready_o, including flush cycles. It holds at 2^CNTW-1.
- Reset mid-operation clears state immediately. On the first edge after deassertion, normal tracking resumes.

Test Plan:
- RAW stall:
  - Issue rd=5 (rd_we_i=1). Next cycle, present rs=5.
  - Required: issue_ready_o=0 and stall_cnt_o increments each cycle.
  - Drive wb_we_i=1, wb_addr_i=5: issue_ready_o=1 and fwd_rs_o=1 in that cycle. pending_o[5]=0 after the edge.
- WAW plus same-cycle set/clear:
  - r7 is pending. Issue rd=7 in the same cycle as a writeback to r7.
  - Required: issue_ready_o=1, pending_o[7] stays 1, pending_cnt_o is unchanged.
- r0 immunity:
  - Issue rd=0, then rs=0 and rt=0.
  - Required: pending_o=0, issue_ready_o=1 throughout, fwd_rs_o=0, fwd_rt_o=0.
- Flush:
  - Set r3, r9 and r31 pending. Assert flush_i together with issue_valid_i and an issue of rd=4.
  - Required: issue_ready_o=0 in that cycle. After the edge, pending_o=0 and pending_cnt_o=0. r4 is not set.
- Async reset mid-stream:
  - Assert rst between clock edges while pending_cnt_o=4.
  - Required: pending_o=0 and pending_cnt_o=0 immediately, with no clock edge needed, and stall_cnt_o=0.
- Fill and count:
  - Issue writes to r1..r31 back-to-back.
  - Required: pending_cnt_o reaches 31.
  - Then write back all of them in a single pass: the count returns to 0. Any source read during the fill stalls unless wb_hit applies.
